load_store_unit: RTL and testbench

Initiator-side load/store controller between the MIPS pipeline's memory stage and the word-only `DataMemory` register array. Accepts byte/halfword/word loads and stores on byte addresses and translates each into word accesses. Performs lane extraction with sign or zero extension for loads, and read-modify-write merging for sub-word stores. Detects misaligned accesses and reports them instead of touching memory.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_lane_align.sv | 52 +++++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned SIZE_W  = 2;
    localparam int unsigned LANE_W  = 8;
    localparam int unsigned WORD_W  = 32;

    // Access size as encoded on req_size; 2'b11 is reserved/illegal.
    typedef enum logic [SIZE_W-1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        STORE = 2'b10,
        RESP  = 2'b11
    } lsu_state_e;

    // True when the access cannot be served by one aligned word access.
    function automatic logic is_misaligned(input logic [SIZE_W-1:0] size,
                                           input logic [1:0]        addr_lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane extraction for loads and lane merging for stores on a 32-bit word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_size_e          size,
    input  logic               is_signed,
    input  logic [1:0]         addr_lo,
    input  logic [WORD_W-1:0]  rd_word,
    input  logic [WORD_W-1:0]  wdata,
    output logic [WORD_W-1:0]  load_data,
    output logic [WORD_W-1:0]  store_word
);

    logic [4:0]          bit_off;
    logic [LANE_W-1:0]   byte_lane;
    logic [2*LANE_W-1:0] half_lane;

    assign bit_off = {addr_lo, 3'b000};

    // Select the addressed byte and halfword lanes of the read word.
    always_comb begin
        byte_lane = rd_word[bit_off +: LANE_W];
        half_lane = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Extend the selected lane for loads; splice store data into the read word.
    always_comb begin
        load_data  = rd_word;
        store_word = wdata;
        case (size)
            BYTE: begin
                load_data  = {{24{is_signed & byte_lane[7]}}, byte_lane};
                store_word = rd_word;
                store_word[bit_off +: LANE_W] = wdata[7:0];
            end
            HALF: begin
                load_data  = {{16{is_signed & half_lane[15]}}, half_lane};
                store_word = rd_word;
                if (addr_lo[1]) begin
                    store_word[31:16] = wdata[15:0];
                end else begin
                    store_word[15:0] = wdata[15:0];
                end
            end
            default: begin
                load_data  = rd_word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store controller in front of a word-only memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data
);

    lsu_state_e        state;
    logic [1:0]        lat_size;
    logic              lat_signed;
    logic [ADDR_W+1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;

    assign word_addr = lat_addr[ADDR_W+1:2];

    lsu_lane_align u_lane_align (
        .size       (lsu_size_e'(lat_size)),
        .is_signed  (lat_signed),
        .addr_lo    (lat_addr[1:0]),
        .rd_word    (mem_rd_data),
        .wdata      (lat_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Request FSM: latch on accept, one access cycle, hold response until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            resp_err <= 1'b1;
                            state    <= RESP;
                        end else if (req_we) begin
                            state <= STORE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= load_data;
                    state      <= RESP;
                end
                STORE: begin
                    state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // Memory port: address only during the access cycle; write gated by reset.
    always_comb begin
        mem_rd_addr = '0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_wr_en   = 1'b0;
        case (state)
            LOAD: begin
                mem_rd_addr = word_addr;
            end
            STORE: begin
                mem_rd_addr = word_addr;
                mem_wr_addr = word_addr;
                mem_wr_data = store_word;
                mem_wr_en   = ~rst;
            end
            default: begin
                mem_rd_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a word memory and a reference model.
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [31:0]       mem_rd_data;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic              mem_wr_en;
    logic [31:0]       mem_wr_data;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        init_we;
    logic [3:0]  init_idx;
    logic [31:0] init_val;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, write on the rising edge.
    assign mem_rd_data = mem[mem_rd_addr];
    always @(posedge clk) begin
        if (init_we) mem[init_idx] <= init_val;
        else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    // ---------------- reference model ----------------
    function automatic bit model_err(input logic [1:0] size, input logic [5:0] addr);
        int nb;
        if (size == 2'd3) return 1'b1;
        nb = 1 << size;
        return (int'(addr) % nb) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [5:0] addr);
        longint unsigned w, mask, v;
        int nb, off;
        nb   = 1 << size;
        off  = int'(addr) % 4;
        w    = 64'(ref_mem[int'(addr) / 4]);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = (w >> (8 * off)) & mask;
        if (sgn && v >= (mask + 64'd1) / 64'd2) v = v - (mask + 64'd1);
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_store(input logic [1:0] size, input logic [5:0] addr,
                                                input logic [31:0] wdata);
        longint unsigned w, mask;
        int nb, off;
        nb   = 1 << size;
        off  = int'(addr) % 4;
        w    = 64'(ref_mem[int'(addr) / 4]);
        mask = ((64'd1 << (8 * nb)) - 64'd1) << (8 * off);
        return 32'((w & ~mask) | ((64'(wdata) << (8 * off)) & mask));
    endfunction

    // Drive one request and observe the DUT until its response (bounded).
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [5:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int wr_cnt, output logic [3:0] wr_addr,
                         output logic [31:0] wr_data);
        int n;
        lat = -1; rdata = '0; err = 1'b0; wr_cnt = 0; wr_addr = '0; wr_data = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_wr_en) begin wr_cnt++; wr_addr = mem_wr_addr; wr_data = mem_wr_data; end
            if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_err; break; end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1; init_we = 1'b0;
        init_idx = '0; init_val = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            init_we = 1'b1; init_idx = 4'(i); init_val = $urandom; ref_mem[i] = init_val;
        end
        @(negedge clk);
        init_we = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_mem_wr_en: got %b expected 0", mem_wr_en); end
        checks++; if ({mem_rd_addr, mem_wr_addr, mem_wr_data} !== '0) begin errors++;
            $display("FAIL reset_mem_port: got rd=%h wr=%h data=%h expected 0", mem_rd_addr, mem_wr_addr, mem_wr_data); end
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } dir_t;

    task automatic test_directed();
        dir_t tbl [8];
        int lat, wr_cnt;
        logic [31:0] rdata, wr_data;
        logic [3:0] wr_addr;
        logic err;
        tbl[0] = '{1'b1, 2'd2, 1'b0, 6'h08, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 2'd0, 1'b1, 6'h09, 32'h0,        32'hFFFFFFBE};
        tbl[2] = '{1'b0, 2'd0, 1'b0, 6'h09, 32'h0,        32'h000000BE};
        tbl[3] = '{1'b0, 2'd2, 1'b0, 6'h08, 32'h0,        32'hDEADBEEF};
        tbl[4] = '{1'b1, 2'd0, 1'b0, 6'h0B, 32'hAAAAAA12, 32'h12ADBEEF};
        tbl[5] = '{1'b0, 2'd1, 1'b1, 6'h0A, 32'h0,        32'h000012AD};
        tbl[6] = '{1'b0, 2'd1, 1'b1, 6'h08, 32'h0,        32'hFFFFBEEF};
        tbl[7] = '{1'b0, 2'd1, 1'b0, 6'h08, 32'h0,        32'h0000BEEF};
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
                  lat, rdata, err, wr_cnt, wr_addr, wr_data);
            checks++; if (lat !== 2) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected 2", i, lat); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL dir_err[%0d]: got %b expected 0", i, err); end
            if (tbl[i].we) begin
                checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL dir_wr_cnt[%0d]: got %0d expected 1", i, wr_cnt); end
                checks++; if (wr_addr !== 4'd2) begin errors++; $display("FAIL dir_wr_addr[%0d]: got %0d expected 2", i, wr_addr); end
                checks++; if (wr_data !== tbl[i].exp) begin errors++; $display("FAIL dir_wr_data[%0d]: got %h expected %h", i, wr_data, tbl[i].exp); end
                checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL dir_store_rdata[%0d]: got %h expected 0", i, rdata); end
                ref_mem[2] = tbl[i].exp;
            end else begin
                checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL dir_load_wr[%0d]: got %0d expected 0", i, wr_cnt); end
                checks++; if (rdata !== tbl[i].exp) begin errors++; $display("FAIL dir_rdata[%0d]: got %h expected %h", i, rdata, tbl[i].exp); end
            end
        end
    endtask

    task automatic test_misaligned();
        dir_t tbl [3];
        int lat, wr_cnt, wa;
        logic [31:0] rdata, wr_data;
        logic [3:0] wr_addr;
        logic err;
        tbl[0] = '{1'b0, 2'd2, 1'b0, 6'h06, 32'h0,        32'h0};
        tbl[1] = '{1'b1, 2'd1, 1'b0, 6'h05, 32'h0000FFFF, 32'h0};
        tbl[2] = '{1'b1, 2'd3, 1'b0, 6'h08, 32'h13572468, 32'h0};
        for (int i = 0; i < 3; i++) begin
            issue(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
                  lat, rdata, err, wr_cnt, wr_addr, wr_data);
            @(negedge clk);
            wa = int'(tbl[i].addr) / 4;
            checks++; if (lat !== 1) begin errors++; $display("FAIL mis_latency[%0d]: got %0d expected 1", i, lat); end
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err[%0d]: got %b expected 1", i, err); end
            checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata[%0d]: got %h expected 0", i, rdata); end
            checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL mis_wr_cnt[%0d]: got %0d expected 0", i, wr_cnt); end
            checks++; if (mem[wa] !== ref_mem[wa]) begin errors++; $display("FAIL mis_mem[%0d]: got %h expected %h", i, mem[wa], ref_mem[wa]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        exp = model_load(2'd2, 1'b0, 6'h08);
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 6'h08; req_wdata = '0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 6'h14; req_wdata = 32'h55555555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, resp_valid); end
            checks++; if (resp_rdata !== exp) begin errors++; $display("FAIL bp_rdata[%0d]: got %h expected %h", i, resp_rdata, exp); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, req_ready); end
            checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL bp_wr_en[%0d]: got %b expected 0", i, mem_wr_en); end
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", req_ready); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL bp_release_rdata: got %h expected 0", resp_rdata); end
        checks++; if (mem[5] !== ref_mem[5]) begin errors++; $display("FAIL bp_mem5: got %h expected %h", mem[5], ref_mem[5]); end
    endtask

    task automatic test_reset_store();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 6'h1C; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_store_wr_en: got %b expected 0", mem_wr_en); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_store_req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_store_resp_valid: got %b expected 0", resp_valid); end
        checks++; if ({resp_rdata, resp_err} !== '0) begin errors++; $display("FAIL rst_store_resp: got %h/%b expected 0/0", resp_rdata, resp_err); end
        checks++; if ({mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en} !== '0) begin errors++;
            $display("FAIL rst_store_mem_port: got rd=%h wr=%h data=%h en=%b expected 0", mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en); end
        checks++; if (mem[7] !== ref_mem[7]) begin errors++; $display("FAIL rst_store_mem7: got %h expected %h", mem[7], ref_mem[7]); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_store_no_resp: got %b expected 0", resp_valid); end
    endtask

    task automatic test_random();
        int lat, wr_cnt, exp_lat, wa;
        logic [31:0] rdata, wr_data, exp_word, wdata;
        logic [3:0] wr_addr;
        logic err, we, sgn, exp_err;
        logic [1:0] size;
        logic [5:0] addr;
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom); sgn = 1'($urandom);
            size = 2'($urandom_range(0, 3)); addr = 6'($urandom); wdata = $urandom;
            if (size != 2'd3 && $urandom_range(0, 3) != 0) addr = addr & ~6'((1 << size) - 1);
            wa = int'(addr) / 4;
            exp_err = model_err(size, addr);
            exp_lat = exp_err ? 1 : 2;
            issue(we, size, sgn, addr, wdata, lat, rdata, err, wr_cnt, wr_addr, wr_data);
            checks++; if (lat !== exp_lat || err !== exp_err) begin errors++;
                $display("FAIL rnd_timing[%0d]: got lat=%0d err=%b expected lat=%0d err=%b", i, lat, err, exp_lat, exp_err); end
            if (exp_err) begin
                checks++; if (rdata !== 32'h0 || wr_cnt !== 0) begin errors++;
                    $display("FAIL rnd_err_side[%0d]: got rdata=%h wr=%0d expected 0/0", i, rdata, wr_cnt); end
            end else if (we) begin
                exp_word = model_store(size, addr, wdata);
                checks++; if (wr_cnt !== 1 || wr_addr !== 4'(wa) || wr_data !== exp_word) begin errors++;
                    $display("FAIL rnd_store[%0d]: got n=%0d a=%0d d=%h expected 1/%0d/%h", i, wr_cnt, wr_addr, wr_data, wa, exp_word); end
                ref_mem[wa] = exp_word;
            end else begin
                checks++; if (rdata !== model_load(size, sgn, addr) || wr_cnt !== 0) begin errors++;
                    $display("FAIL rnd_load[%0d]: got %h wr=%0d expected %h wr=0", i, rdata, wr_cnt, model_load(size, sgn, addr)); end
            end
        end
        @(negedge clk);
        for (int k = 0; k < int'(DEPTH); k++) begin
            checks++; if (mem[k] !== ref_mem[k]) begin errors++; $display("FAIL rnd_mem[%0d]: got %h expected %h", k, mem[k], ref_mem[k]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_misaligned();
        test_backpressure();
        test_reset_store();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
